pwm_motor: RTL and testbench
============================

// Module: pwm_motor
// PURPOSE
//  Two-channel motor PWM peripheral and CtrBus slave, downstream of the data-bus address mux.
//  Mux gates req/we by address decode; block returns gnt/rvalid/rdata/err to the mux.
//  Drives H-bridge PWM and direction pins for the 2WD chassis.
//  Period/duty writes are shadowed and take effect only at a period boundary (glitch-free).
// PARAMETERS
//  ADDR_W  5   byte-address bits decoded (register offset field)
//  CNT_W   16  width of prescaler, period, duty and counter
// PORTS
//  Clk     in   1       system clock
//  Rst     in   1       async reset, active-high
//  req     in   1       bus request (already qualified by mux select)
//  we      in   1       write enable, valid with req
//  be      in   4       byte enables, valid with req && we
//  addr    in   ADDR_W  byte offset within block
//  wdata   in   32      write data
//  gnt     out  1       grant
//  rvalid  out  1       response valid
//  rdata   out  32      read data, valid with rvalid
//  err     out  1       error response, valid with rvalid
//  pwm_o   out  2       PWM outputs, ch1..ch0
//  dir_o   out  2       direction outputs, ch1..ch0
//  irq_o   out  1       wrap interrupt (PWM_IRQ_EN only)
// BEHAVIOUR
//  Reset: all registers, counters and shadows = 0; gnt, rvalid, err, pwm_o, dir_o, irq_o = 0; rdata = 0.
//  Bus handshake:
//   - gnt = req, combinational; every request is accepted in its cycle.
//   - rvalid pulses exactly 1 cycle after each accepted req (read or write); back-to-back requests are supported.
//   - rdata/err are registered with rvalid; rdata = 0 when !rvalid or on write.
//  Register map (offset, access):
//   - 0x00 CTRL rw: [0] EN, [1] DIR0, [2] DIR1, [3] IRQEN.
//   - 0x04 PRESC rw; 0x08 PERIOD rw; 0x0C DUTY0 rw; 0x10 DUTY1 rw.
//   - 0x14 CNT ro (writes ignored, no err).
//   - 0x18 STATUS: [0] WRAP; writing 1 clears it (W1C).
//   - Offsets 0x1C+ or misaligned addr[1:0] != 0: err = 1, rdata = 0, no state change.
//   - Writes honour be per byte; bits above CNT_W read 0.
//  Counting:
//   - When EN = 1, psc counts 0..PRESC. tick = (psc == PRESC), after which psc returns to 0.
//   - On tick, cnt increments. If cnt == period_sh, cnt wraps to 0 and wrap fires.
//  On wrap: period_sh <= PERIOD, duty_sh[i] <= DUTYi, and WRAP is set.
//   - Same-cycle set and W1C: set wins.
//  Outputs:
//   - pwm_o[i] = EN && (cnt < duty_sh[i]), registered (1-cycle latency).
//   - duty 0 gives a constant low output; duty > period gives a constant high output.
//   - dir_o[i] = DIRi, registered; changes immediately regardless of EN.
//  PERIOD = 0: cnt stays 0, every tick is a wrap; output is high iff duty_sh > 0.
//  EN 1->0: psc, cnt and pwm_o clear next cycle; shadows load from live registers every cycle while EN = 0.
//  Reset mid-period: everything returns to reset values asynchronously; no partial pulse persists.
// CONFIGURATION
//  PWM_IRQ_EN defined: IRQEN is implemented; irq_o = WRAP && IRQEN, registered; level output held until W1C.
//  PWM_IRQ_EN undefined: CTRL[3] reads 0 and ignores writes; irq_o is tied 0.
// STRUCTURE
//  pwm_pkg holds:
//   - register offset localparams (REG_CTRL..REG_STATUS);
//   - CTRL bit-index constants;
//   - typedef struct packed ctrl_t;
//   - CNT_W default constant.
//  Sub-module pwm_channel (one per channel): duty shadow register, comparator, registered pwm output.
//  Top level holds bus decode, register file, prescaler, counter, WRAP/irq logic.
// TESTING
//  - Reset: assert Rst mid-run with pwm_o high -> all outputs 0 asynchronously; all registers read back 0.
//  - Basic PWM: PRESC=0, PERIOD=9, DUTY0=3, EN=1 -> pwm_o[0] high 3 of every 10 cycles; WRAP set after the first wrap.
//  - Shadowing: write DUTY0=7 at cnt=2 -> current period keeps duty 3; the next period shows 7 high cycles.
//  - Edge duties: DUTY1=0 -> pwm_o[1] constantly 0; DUTY1=10 with PERIOD=9 -> constantly 1; PERIOD=0 with DUTY0=1 -> constantly 1.
//  - Bus: back-to-back write/read of 0x08 -> gnt same cycle, rvalid each next cycle, read returns the written value.
//    Access to 0x1C -> err=1. Write to CNT is ignored. be=4'b0001 write alters only [7:0].
//  - IRQ (PWM_IRQ_EN): IRQEN=1, wait for wrap -> irq_o=1. W1C STATUS -> irq_o=0 next cycle, unless a new wrap occurs that same cycle.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the two-channel motor PWM peripheral: register map,
// CTRL layout and the byte-enable merge helper.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_PRESC  = 8'h04;
    localparam logic [7:0] REG_PERIOD = 8'h08;
    localparam logic [7:0] REG_DUTY0  = 8'h0C;
    localparam logic [7:0] REG_DUTY1  = 8'h10;
    localparam logic [7:0] REG_CNT    = 8'h14;
    localparam logic [7:0] REG_STATUS = 8'h18;
    localparam logic [7:0] REG_END    = 8'h1C;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_DIR0  = 1;
    localparam int CTRL_DIR1  = 2;
    localparam int CTRL_IRQEN = 3;

    typedef struct packed {
        logic irqen;
        logic dir1;
        logic dir0;
        logic en;
    } ctrl_t;

    // Merge the enabled byte lanes of wdata into an existing register word.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register, compare against the shared counter,
// and the registered pwm output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_sh;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            duty_sh <= '0;
            pwm     <= 1'b0;
        end else begin
            if (load) duty_sh <= duty;
            pwm <= en && (cnt < duty_sh);
        end
    end

endmodule

// File: rtl/pwm_motor.sv
// Two-channel H-bridge PWM peripheral with CtrBus slave interface.
// Build option: define PWM_IRQ_EN to implement CTRL.IRQEN and the irq_o output.
module pwm_motor
    import pwm_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = CNT_W_DEF
)
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              gnt,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        pwm_o,
    output logic [1:0]        dir_o,
    output logic              irq_o
);

    ctrl_t            ctrl, ctrl_d;
    logic [CNT_W-1:0] presc, presc_d;
    logic [CNT_W-1:0] period, period_d;
    logic [CNT_W-1:0] duty0, duty0_d;
    logic [CNT_W-1:0] duty1, duty1_d;
    logic             wrap_flag, wrap_d;

    logic [CNT_W-1:0] psc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_sh;

    logic [7:0]  off;
    logic        bad_addr;
    logic        wr_ok;
    logic        tick;
    logic        wrap;
    logic        shadow_load;
    logic [31:0] cur_word;
    logic [31:0] new_word;

    assign gnt      = req;
    assign off      = 8'(addr);
    assign bad_addr = (off[1:0] != 2'b00) || (off >= REG_END);
    assign wr_ok    = req && we && !bad_addr;

    assign tick        = ctrl.en && (psc == presc);
    assign wrap        = tick && (cnt == period_sh);
    assign shadow_load = !ctrl.en || wrap;

    // Current value of the addressed register; doubles as read data.
    always_comb begin
        case (off)
            REG_CTRL:   cur_word = {28'd0, ctrl};
            REG_PRESC:  cur_word = 32'(presc);
            REG_PERIOD: cur_word = 32'(period);
            REG_DUTY0:  cur_word = 32'(duty0);
            REG_DUTY1:  cur_word = 32'(duty1);
            REG_CNT:    cur_word = 32'(cnt);
            REG_STATUS: cur_word = {31'd0, wrap_flag};
            default:    cur_word = 32'd0;
        endcase
    end

    assign new_word = apply_be(cur_word, wdata, be);

    always_comb begin
        ctrl_d   = ctrl;
        presc_d  = presc;
        period_d = period;
        duty0_d  = duty0;
        duty1_d  = duty1;
        wrap_d   = wrap_flag;
        if (wr_ok) begin
            case (off)
                REG_CTRL:   ctrl_d   = ctrl_t'(new_word[3:0]);
                REG_PRESC:  presc_d  = new_word[CNT_W-1:0];
                REG_PERIOD: period_d = new_word[CNT_W-1:0];
                REG_DUTY0:  duty0_d  = new_word[CNT_W-1:0];
                REG_DUTY1:  duty1_d  = new_word[CNT_W-1:0];
                REG_STATUS: if (be[0] && wdata[0]) wrap_d = 1'b0;
                default:    ;
            endcase
        end
`ifndef PWM_IRQ_EN
        ctrl_d.irqen = 1'b0;
`endif
        // A wrap in the same cycle as a W1C keeps the flag set.
        if (wrap) wrap_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl      <= '0;
            presc     <= '0;
            period    <= '0;
            duty0     <= '0;
            duty1     <= '0;
            wrap_flag <= 1'b0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            ctrl      <= ctrl_d;
            presc     <= presc_d;
            period    <= period_d;
            duty0     <= duty0_d;
            duty1     <= duty1_d;
            wrap_flag <= wrap_d;
            rvalid    <= req;
            err       <= req && bad_addr;
            rdata     <= (req && !we && !bad_addr) ? cur_word : 32'd0;
        end
    end

    // Prescaler, period counter and period shadow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            psc       <= '0;
            cnt       <= '0;
            period_sh <= '0;
        end else if (!ctrl.en) begin
            psc       <= '0;
            cnt       <= '0;
            period_sh <= period;
        end else if (tick) begin
            psc <= '0;
            if (cnt == period_sh) begin
                cnt       <= '0;
                period_sh <= period;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            psc <= psc + CNT_W'(1);
        end
    end

    pwm_channel #(.CNT_W(CNT_W)) u_ch0 (
        .Clk  (Clk),
        .Rst  (Rst),
        .en   (ctrl.en),
        .load (shadow_load),
        .duty (duty0),
        .cnt  (cnt),
        .pwm  (pwm_o[0])
    );

    pwm_channel #(.CNT_W(CNT_W)) u_ch1 (
        .Clk  (Clk),
        .Rst  (Rst),
        .en   (ctrl.en),
        .load (shadow_load),
        .duty (duty1),
        .cnt  (cnt),
        .pwm  (pwm_o[1])
    );

    assign dir_o = {ctrl.dir1, ctrl.dir0};

`ifdef PWM_IRQ_EN
    logic irq_q;

    // Built from next-state values so irq_o tracks WRAP && IRQEN with no extra lag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) irq_q <= 1'b0;
        else     irq_q <= wrap_d && ctrl_d.irqen;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_motor.sv
// Self-checking bench for pwm_motor: register-map vector table, arithmetic
// PWM waveform model, shadowing/IRQ/reset sequences and a randomized bus model.
`timescale 1ns/1ps
module tb_pwm_motor;
    import pwm_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [4:0]  addr = 5'h0;
    logic [31:0] wdata = 32'h0;
    logic        gnt, rvalid, err, irq_o;
    logic [31:0] rdata;
    logic [1:0]  pwm_o, dir_o;

    int checks = 0;
    int errors = 0;

    pwm_motor #(.ADDR_W(5), .CNT_W(16)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .pwm_o  (pwm_o),
        .dir_o  (dir_o),
        .irq_o  (irq_o)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rdv, output logic ev);
        @(negedge Clk);
        req = 1'b1; we = w; addr = a[4:0]; be = b; wdata = d;
        #1 check("gnt", 32'(gnt), 32'd1);
        @(posedge Clk); #1;
        req = 1'b0; we = 1'b0;
        check("rvalid", 32'(rvalid), 32'd1);
        rdv = rdata;
        ev  = err;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rdv;
        logic ev;
        bus(1'b1, a, 4'hF, d, rdv, ev);
        check("wr_err", 32'(ev), 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rdv;
        logic ev;
        bus(1'b0, a, 4'hF, 32'd0, rdv, ev);
        check(name, rdv, exp);
        check({name, "_err"}, 32'(ev), 32'd0);
    endtask

    // Configure with EN=0, enable, then compare every cycle against the
    // ideal waveform: in cycle t after enable, pwm reflects the count value
    // of cycle t-1, which is ((t-1)/(presc+1)) mod (period+1).
    task automatic run_pwm(input int p, input int n, input int d0, input int d1,
                           input logic [1:0] dir, input string tag);
        int cyc, k, c;
        logic [1:0] exp;
        wr(REG_CTRL, 32'd0);
        wr(REG_PRESC, p);
        wr(REG_PERIOD, n);
        wr(REG_DUTY0, d0);
        wr(REG_DUTY1, d1);
        wr(REG_CTRL, {29'd0, dir, 1'b1});
        check({tag, "_dir"}, 32'(dir_o), 32'(dir));
        cyc = 2 * (p + 1) * (n + 1) + 3;
        for (int t = 1; t <= cyc; t++) begin
            @(posedge Clk); #1;
            k = t - 1;
            c = (k / (p + 1)) % (n + 1);
            exp[0] = (c < d0);
            exp[1] = (c < d1);
            check({tag, "_pwm"}, 32'(pwm_o), 32'(exp));
        end
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[23];

`ifdef PWM_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h0000_000E;
`else
    localparam logic [31:0] CTRL_RB = 32'h0000_0006;
`endif

    initial begin
        logic [31:0] rdv;
        logic        ev;
        int          h1, h2, waited;
        logic [15:0] m_reg [4];

        vecs[0]  = '{1'b1, REG_PERIOD, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, REG_PERIOD, 4'hF, 32'h0,         1'b0, 32'h0000_5678};
        vecs[2]  = '{1'b1, REG_PERIOD, 4'h1, 32'h0000_00AB, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, REG_PERIOD, 4'hF, 32'h0,         1'b0, 32'h0000_56AB};
        vecs[4]  = '{1'b1, REG_PERIOD, 4'h2, 32'h0000_CD00, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, REG_PERIOD, 4'hF, 32'h0,         1'b0, 32'h0000_CDAB};
        vecs[6]  = '{1'b1, REG_CNT,    4'hF, 32'h0000_FFFF, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, REG_CNT,    4'hF, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b0, 8'h1C,      4'hF, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 8'h1C,      4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 8'h06,      4'hF, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{1'b1, REG_PRESC,  4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, REG_PRESC,  4'hF, 32'h0,         1'b0, 32'h0000_BEEF};
        vecs[13] = '{1'b1, REG_CTRL,   4'h1, 32'h0000_000E, 1'b0, 32'h0};
        vecs[14] = '{1'b0, REG_CTRL,   4'hF, 32'h0,         1'b0, CTRL_RB};
        vecs[15] = '{1'b1, REG_CTRL,   4'hF, 32'h0,         1'b0, 32'h0};
        vecs[16] = '{1'b0, REG_STATUS, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[17] = '{1'b1, REG_DUTY1,  4'hF, 32'hFFFF_1111, 1'b0, 32'h0};
        vecs[18] = '{1'b0, REG_DUTY1,  4'hF, 32'h0,         1'b0, 32'h0000_1111};
        vecs[19] = '{1'b1, REG_DUTY0,  4'h0, 32'h0000_FFFF, 1'b0, 32'h0};
        vecs[20] = '{1'b0, REG_DUTY0,  4'hF, 32'h0,         1'b0, 32'h0};
        vecs[21] = '{1'b1, 8'h09,      4'hF, 32'h0,         1'b1, 32'h0};
        vecs[22] = '{1'b0, REG_PERIOD, 4'hF, 32'h0,         1'b0, 32'h0000_CDAB};

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_dir", 32'(dir_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        Rst = 1'b0;
        for (int o = 0; o <= 8'h18; o += 4) rd_chk("rst_reg", 8'(o), 32'd0);

        // Register-map vector table
        for (int i = 0; i < 23; i++) begin
            bus(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, rdv, ev);
            check($sformatf("vec%0d_rdata", i), rdv, vecs[i].r);
            check($sformatf("vec%0d_err", i), 32'(ev), 32'(vecs[i].e));
        end

        // Back-to-back write then read of PERIOD
        @(negedge Clk);
        req = 1'b1; we = 1'b1; addr = 5'h08; be = 4'hF; wdata = 32'h0000_0042;
        #1 check("b2b_gnt_wr", 32'(gnt), 32'd1);
        @(posedge Clk); #1;
        check("b2b_rvalid_wr", 32'(rvalid), 32'd1);
        check("b2b_rdata_wr", rdata, 32'd0);
        we = 1'b0;
        #1 check("b2b_gnt_rd", 32'(gnt), 32'd1);
        @(posedge Clk); #1;
        check("b2b_rvalid_rd", 32'(rvalid), 32'd1);
        check("b2b_rdata_rd", rdata, 32'h0000_0042);
        req = 1'b0;
        @(posedge Clk); #1;
        check("idle_rvalid", 32'(rvalid), 32'd0);
        check("idle_rdata", rdata, 32'd0);

        // Basic PWM and WRAP flag, then edge duties
        run_pwm(0, 9, 3, 0, 2'b01, "basic");
        rd_chk("wrap_set", REG_STATUS, 32'd1);
        run_pwm(0, 9, 3, 10, 2'b10, "duty_gt_period");
        run_pwm(0, 0, 1, 0, 2'b11, "period0");
        run_pwm(2, 4, 0, 5, 2'b00, "presc2");

        for (int i = 0; i < 8; i++) begin
            int p, n;
            p = $urandom_range(0, 3);
            n = $urandom_range(0, 7);
            run_pwm(p, n, $urandom_range(0, n + 2), $urandom_range(0, n + 2),
                    2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        // Shadowing: DUTY0 change at cnt=2 shows up only in the next period
        wr(REG_CTRL, 32'd0);
        wr(REG_PRESC, 32'd0);
        wr(REG_PERIOD, 32'd9);
        wr(REG_DUTY0, 32'd3);
        wr(REG_DUTY1, 32'd0);
        wr(REG_CTRL, 32'd1);
        h1 = 0;
        h2 = 0;
        fork
            begin
                for (int t = 1; t <= 20; t++) begin
                    @(posedge Clk); #1;
                    if (pwm_o[0]) begin
                        if (t <= 10) h1++;
                        else h2++;
                    end
                end
            end
            begin
                @(posedge Clk);
                @(posedge Clk);
                wr(REG_DUTY0, 32'd7);
            end
        join
        check("shadow_cur_period", 32'(h1), 32'd3);
        check("shadow_next_period", 32'(h2), 32'd7);

        // Interrupt
        wr(REG_CTRL, 32'd0);
        wr(REG_STATUS, 32'd1);
        wr(REG_PRESC, 32'd1);
        wr(REG_PERIOD, 32'd9);
        wr(REG_CTRL, 32'h9);
`ifdef PWM_IRQ_EN
        waited = 0;
        while (!irq_o && waited < 200) begin
            @(posedge Clk); #1;
            waited++;
        end
        check("irq_set", 32'(irq_o), 32'd1);
        wr(REG_STATUS, 32'd1);
        check("irq_w1c", 32'(irq_o), 32'd0);
        wr(REG_CTRL, 32'd0);
        wr(REG_PRESC, 32'd0);
        wr(REG_PERIOD, 32'd0);
        wr(REG_CTRL, 32'h9);
        repeat (2) @(posedge Clk);
        wr(REG_STATUS, 32'd1);
        check("irq_set_wins", 32'(irq_o), 32'd1);
        rd_chk("wrap_set_wins", REG_STATUS, 32'd1);
`else
        waited = 0;
        repeat (60) begin
            @(posedge Clk); #1;
            if (irq_o) waited++;
        end
        check("irq_tied_low", 32'(waited), 32'd0);
        rd_chk("ctrl_no_irqen", REG_CTRL, 32'h1);
        rd_chk("wrap_noirq", REG_STATUS, 32'd1);
`endif

        // Asynchronous reset mid-period with pwm high
        wr(REG_CTRL, 32'd0);
        wr(REG_PRESC, 32'd0);
        wr(REG_PERIOD, 32'd9);
        wr(REG_DUTY0, 32'd5);
        wr(REG_DUTY1, 32'd5);
        wr(REG_CTRL, 32'h7);
        repeat (2) @(posedge Clk);
        #2;
        check("pre_rst_pwm", 32'(pwm_o), 32'd3);
        Rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_o), 32'd0);
        check("async_rst_dir", 32'(dir_o), 32'd0);
        check("async_rst_irq", 32'(irq_o), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int o = 0; o <= 8'h18; o += 4) rd_chk("post_rst_reg", 8'(o), 32'd0);

        // Randomized bus traffic against a register model (EN stays 0)
        for (int j = 0; j < 4; j++) m_reg[j] = 16'd0;
        for (int i = 0; i < 60; i++) begin
            logic        w, exp_e;
            logic [7:0]  a;
            logic [3:0]  b;
            logic [31:0] d, exp_r;
            int          idx;
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(1, 31));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            idx = int'(a) / 4;
            exp_e = (a[1:0] != 2'b00) || (a >= 8'h1C);
            exp_r = 32'd0;
            if (!exp_e && idx >= 1 && idx <= 4) begin
                if (w) begin
                    for (int k = 0; k < 2; k++)
                        if (b[k]) m_reg[idx - 1][k*8 +: 8] = d[k*8 +: 8];
                end else begin
                    exp_r = {16'd0, m_reg[idx - 1]};
                end
            end
            bus(w, a, b, d, rdv, ev);
            check($sformatf("rnd%0d_rdata", i), rdv, exp_r);
            check($sformatf("rnd%0d_err", i), 32'(ev), 32'(exp_e));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
